// File: rtl/match_score_accum.sv
// Match score accumulator: aligns issue validity to the multiplier latency and sums LEN products per window.
// Optional: define MATCH_SCORE_SAT_EN to saturate the accumulator instead of wrapping.
module match_score_accum #(
    parameter int LEN    = 256,
    parameter int LAT    = 3,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] product,
    input  logic [ACC_W-1:0]  threshold,
    output logic              issue_ok,
    output logic              busy,
    output logic [ACC_W-1:0]  score,
    output logic              match,
    output logic              score_valid,
    input  logic              score_ready
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] prod_cnt;
    logic [LAT-1:0]   vld_p;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] thr;
    logic             issue;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [PROD_W-1:0] p);
`ifdef MATCH_SCORE_SAT_EN
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W + 1)'(p);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        return a + ACC_W'(p);
`endif
    endfunction

    assign issue_ok    = (state == ACCUM) && (issue_cnt < LEN_C);
    assign issue       = in_valid && issue_ok;
    assign busy        = (state != IDLE);
    assign score_valid = (state == HOLD);
    assign score       = acc;
    // match is only meaningful once the window is complete; zero elsewhere keeps reset/idle quiet
    assign match       = (state == HOLD) && (acc >= thr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            prod_cnt  <= '0;
            vld_p     <= '0;
            acc       <= '0;
            thr       <= '0;
        end else begin
            // valid delay line: stage LAT-1 lines up with the product of that issue
            vld_p[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        issue_cnt <= '0;
                        prod_cnt  <= '0;
                        thr       <= threshold;
                    end
                end
                ACCUM: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (vld_p[LAT-1]) begin
                        acc      <= acc_add(acc, product);
                        prod_cnt <= prod_cnt + 1'b1;
                        if (prod_cnt == LEN_C - 1'b1) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (score_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_score_accum.sv
// Bench for match_score_accum: directed test-plan windows plus randomized windows against a sum-of-products model.
module tb_match_score_accum;

    localparam int LEN    = 4;
    localparam int LAT    = 3;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 20;
    localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  threshold;
    logic              issue_ok;
    logic              busy;
    logic [ACC_W-1:0]  score;
    logic              match;
    logic              score_valid;
    logic              score_ready;

    logic [15:0]       op_a;
    logic [3:0]        op_b;
    logic [PROD_W-1:0] mp0, mp1, mp2;

    int ncmp  = 0;
    int nfail = 0;
    int unsigned a_q[$];
    int unsigned b_q[$];
    int unsigned gap_q[$];

    match_score_accum #(.LEN(LEN), .LAT(LAT), .PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .product(product), .threshold(threshold), .issue_ok(issue_ok),
        .busy(busy), .score(score), .match(match), .score_valid(score_valid),
        .score_ready(score_ready)
    );

    always #5 clk = ~clk;

    // 16x4 multiplier with 3-cycle latency; it keeps running on garbage operands between issues
    always @(posedge clk) begin
        mp0 <= PROD_W'(op_a) * PROD_W'(op_b);
        mp1 <= mp0;
        mp2 <= mp1;
    end
    assign product = mp2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_score();
        logic [63:0] tot;
        tot = 64'd0;
        foreach (a_q[i]) tot += 64'(a_q[i]) * 64'(b_q[i]);
`ifdef MATCH_SCORE_SAT_EN
        if (tot > ACC_MAX) tot = ACC_MAX;
`else
        tot = tot & ACC_MAX;
`endif
        return tot;
    endfunction

    task automatic load(input int unsigned a, input int unsigned b0, input int unsigned bstep,
                        input int unsigned gap);
        a_q.delete(); b_q.delete(); gap_q.delete();
        for (int i = 0; i < LEN; i++) begin
            a_q.push_back(a);
            b_q.push_back(b0 + bstep * i);
            gap_q.push_back(i == 0 ? 0 : gap);
        end
    endtask

    // start is in cycle 0; returns the cycle score_valid was first seen and the last issue cycle
    task automatic run_window(input string tag, input logic [ACC_W-1:0] thr, input bit overrun,
                              input bit early_ready, output int vcyc, output int lcyc);
        int idx, gap, cyc;
        bit seen_full;
        logic [63:0] exp;
        exp = model_score();
        start = 1'b1; threshold = thr; score_ready = early_ready;
        tick();
        start = 1'b0; threshold = ACC_W'($urandom);
        cyc = 1; idx = 0; gap = int'(gap_q[0]); lcyc = 0; seen_full = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_issue_ok"}, 64'(issue_ok), 64'd1);
        while (!score_valid && cyc < 200) begin
            op_a = 16'($urandom); op_b = 4'($urandom);
            if (idx < LEN) begin
                if (gap > 0) begin
                    in_valid = 1'b0;
                    gap--;
                end else begin
                    in_valid = 1'b1;
                    op_a = 16'(a_q[idx]); op_b = 4'(b_q[idx]);
                    lcyc = cyc;
                    idx++;
                    if (idx < LEN) gap = int'(gap_q[idx]);
                end
            end else begin
                if (overrun && !seen_full) begin
                    check({tag, "_issue_ok_full"}, 64'(issue_ok), 64'd0);
                    seen_full = 1'b1;
                end
                in_valid = overrun;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        vcyc = cyc;
        check({tag, "_valid"}, 64'(score_valid), 64'd1);
        check({tag, "_score"}, 64'(score), exp);
        check({tag, "_match"}, 64'(match), 64'(exp >= 64'(thr)));
        check({tag, "_lat"}, 64'(vcyc - lcyc), 64'(LAT + 1));
    endtask

    task automatic finish_window(input string tag);
        score_ready = 1'b1;
        tick();
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(score_valid), 64'd0);
        score_ready = 1'b0;
    endtask

    initial begin
        int v, l;
        logic [63:0] exp;
        logic [ACC_W-1:0] thr;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; score_ready = 1'b0;
        threshold = '0; op_a = '0; op_b = '0;
        #2;
        check("rst_issue_ok", 64'(issue_ok), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_match", 64'(match), 64'd0);
        check("rst_valid", 64'(score_valid), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        load(100, 3, 0, 0);
        run_window("basic", 20'd1000, 1'b0, 1'b0, v, l);
        check("basic_start_to_valid", 64'(v), 64'(LEN + LAT + 1));
        finish_window("basic");
        run_window("thr1200", 20'd1200, 1'b0, 1'b0, v, l);
        check("thr1200_match", 64'(match), 64'd1);
        finish_window("thr1200");
        run_window("thr1201", 20'd1201, 1'b0, 1'b0, v, l);
        check("thr1201_match", 64'(match), 64'd0);
        finish_window("thr1201");

        load(10, 1, 1, 2);
        run_window("bubbles", 20'd50, 1'b1, 1'b0, v, l);
        check("bubbles_score_abs", 64'(score), 64'd100);
        finish_window("bubbles");

        load(100, 3, 0, 0);
        run_window("bp", 20'd1000, 1'b0, 1'b0, v, l);
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            threshold = ACC_W'($urandom);
            tick();
            check("bp_hold_score", 64'(score), 64'd1200);
            check("bp_hold_match", 64'(match), 64'd1);
            check("bp_hold_valid", 64'(score_valid), 64'd1);
        end
        start = 1'b0;
        finish_window("bp");

        start = 1'b1; threshold = 20'd1000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; op_a = 16'd100; op_b = 4'd3;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_issue_ok", 64'(issue_ok), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_score", 64'(score), 64'd0);
        check("midrst_match", 64'(match), 64'd0);
        check("midrst_valid", 64'(score_valid), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        load(100, 3, 0, 0);
        run_window("fresh", 20'd1000, 1'b0, 1'b0, v, l);
        check("fresh_score_abs", 64'(score), 64'd1200);
        finish_window("fresh");

        load(65535, 15, 0, 0);
        run_window("sat", 20'hFFFFF, 1'b0, 1'b1, v, l);
`ifdef MATCH_SCORE_SAT_EN
        check("sat_score_abs", 64'(score), 64'd1048575);
`else
        check("sat_score_abs", 64'(score), 64'd786372);
`endif
        finish_window("sat");

        for (int w = 0; w < 8; w++) begin
            a_q.delete(); b_q.delete(); gap_q.delete();
            for (int i = 0; i < LEN; i++) begin
                a_q.push_back($urandom_range(0, 65535));
                b_q.push_back($urandom_range(0, 15));
                gap_q.push_back(i == 0 ? $urandom_range(0, 1) : $urandom_range(0, 3));
            end
            exp = model_score();
            case ($urandom_range(0, 2))
                0: thr = ACC_W'(exp);
                1: thr = ACC_W'(exp + 64'd1);
                default: thr = ACC_W'($urandom);
            endcase
            run_window("rand", thr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v, l);
            finish_window("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/match_score_accum.md
# match_score_accum

Downstream consumer of the 16x4 pipelined multiplier in the matching datapath. It tracks validity of the pairs issued into the multiplier, aligns it to the multiplier's 3-cycle latency, and accumulates LEN products into one match score per window. It compares the score with a per-window threshold and hands result and flag to the decision logic over a valid/ready handshake.

## Interface
- LEN, 256, products accumulated per score window (>=1)
- LAT, 3, multiplier latency in cycles, issue to outProduct
- PROD_W, 32, product width
- ACC_W, 40, accumulator / score / threshold width (>= PROD_W)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a new window; honoured only in IDLE
- in_valid  in  1  A/B pair presented to the multiplier this cycle is valid
- product  in  PROD_W  multiplier outProduct
- threshold  in  ACC_W  sampled on accepted start
- issue_ok  out  1  high in ACCUM while fewer than LEN pairs have been issued; upstream issues only when high
- busy  out  1  state != IDLE
- score  out  ACC_W  accumulated score
- match  out  1  score >= latched threshold (unsigned)
- score_valid  out  1  result held
- score_ready  in  1  consumer accepts result

## Operation
- States:
  - IDLE: start -> ACCUM. On the same edge: clear acc, clear both counters, latch threshold.
  - ACCUM: accepted issue = in_valid & issue_ok; the issue counter increments on each one.
  - ACCUM exit: the accepted-product counter reaching LEN -> HOLD.
  - HOLD: score_valid=1. score_valid & score_ready -> IDLE.
- Valid delay line: LAT-stage shift register fed by accepted issue. When the last stage is high, acc += product (zero-extended) and the accepted-product counter increments.
- in_valid is ignored when issue_ok=0, including in IDLE, HOLD, and after LEN issues.
- start is ignored outside IDLE.
- score, match and threshold stay stable throughout HOLD.
- Arithmetic is unsigned. Without the configuration macro, acc wraps modulo 2^ACC_W.
- Counter width: clog2(LEN+1).
- Reset, including mid-window:
  - state returns to IDLE; acc, counters, delay line, latched threshold and all outputs go to 0.
  - Products still in flight are discarded, since the multiplier shares the same reset.

## Timing
- Reset values: issue_ok=0, busy=0, score=0, match=0, score_valid=0.
- start accepted at edge t: busy and issue_ok are high from cycle t+1.
- Issue in cycle k: its product is on `product` during cycle k+LAT and is added at the end of that cycle.
- Last issue in cycle k: score_valid rises in cycle k+LAT+1.
- Minimum window: start in cycle t, score_valid in cycle t+LEN+LAT+1.
- Bubbles in in_valid delay completion cycle-for-cycle and do not affect the score.
- Handshake completes in cycle h (score_valid & score_ready): IDLE from h+1. A start in h+1 is accepted; a start in h is ignored.
- score_ready is allowed high early; it takes effect only in HOLD. No combinational path exists from score_ready to score_valid.

## Configuration
- MATCH_SCORE_SAT_EN defined: acc saturates at 2^ACC_W-1 and never wraps; match still compares the clamped value.
- MATCH_SCORE_SAT_EN not defined: acc wraps modulo 2^ACC_W.

## Test plan
- Basic window (LEN=4, threshold=1000):
  - Stimulus: start, then 4 back-to-back issues of A=100, B=3.
  - Response: score=1200, match=1, score_valid exactly 8 cycles after the start edge.
- Threshold boundary: repeat the basic window with threshold=1200 -> match=1; with threshold=1201 -> match=0.
- Bubbles and overrun (LEN=4):
  - Stimulus: issues A=10, B=1..4 with 2-cycle gaps between them; then in_valid held high after the 4th issue.
  - Response: score=100; extra in_valid ignored (issue_ok=0); score_valid 4 cycles after the last accepted issue.
- Backpressure:
  - Stimulus: score_ready low for 10 cycles in HOLD, with start pulses during HOLD.
  - Response: score/match stable, starts ignored. Raise score_ready -> IDLE next cycle; a new start is then accepted.
- Reset mid-window:
  - Stimulus: assert reset after 2 of 4 issues.
  - Response: all outputs 0 immediately. A fresh window of 4 x (A=100, B=3) then yields 1200, with no stale products.
- Saturation (ACC_W=20, LEN=4):
  - Stimulus: 4 x (A=65535, B=15), each product 983025.
  - Response: with MATCH_SCORE_SAT_EN, score=1048575; without it, score=786372.
